pkt_ring_ctrl: RTL and testbench

PKT_RING_CTRL -- requirements
Module: pkt_ring_ctrl

---
 rtl/pkt_ring_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_pkt_ring_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_ring_ctrl.sv
// Packet ring controller: stores packets into a circular external register file and replays
// committed packets on a ready/valid stream, dropping packets that do not fit.
module pkt_ring_ctrl #(
  parameter int unsigned pBITS  = 8,
  parameter int unsigned pDEPTH = 3072,
  parameter int unsigned pAW    = 12,
  parameter int unsigned pLQ    = 4
) (
  input  logic                     iclk,
  input  logic                     irst_n,
  input  logic                     ivalid,
  input  logic                     isop,
  input  logic                     ieop,
  input  logic [pBITS-1:0]         idata,
  output logic                     omem_wr_en,
  output logic [pAW-1:0]           omem_w_addr,
  output logic [pBITS-1:0]         omem_w_data,
  output logic [pAW-1:0]           omem_r_addr,
  input  logic [pBITS-1:0]         imem_r_data,
  output logic                     ovalid,
  output logic                     osop,
  output logic                     oeop,
  output logic [pBITS-1:0]         odata,
  input  logic                     iready,
  output logic                     odrop,
  output logic [$clog2(pLQ+1)-1:0] opkt_cnt
);

  // One extra bit so a packet or fill level equal to 2^pAW stays representable.
  localparam int unsigned LW = pAW + 1;
  localparam int unsigned QW = (pLQ > 1) ? $clog2(pLQ) : 1;
  localparam int unsigned CW = $clog2(pLQ + 1);
  localparam logic [pAW-1:0] LastAddr = pAW'(pDEPTH - 1);
  localparam logic [LW-1:0]  DepthL   = LW'(pDEPTH);

  typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} wst_e;
  typedef enum logic {R_IDLE, R_SEND} rst_e;

  wst_e           wst_q, wst_d;
  rst_e           rd_st_q, rd_st_d;
  logic [pAW-1:0] wr_ptr_q, wr_ptr_d;
  logic [pAW-1:0] cm_ptr_q, cm_ptr_d;
  logic [pAW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  len_q, len_d;
  logic [LW-1:0]  used_q, used_d;
  logic [LW-1:0]  rem_q, rem_d;
  logic           first_q, first_d;
  logic [LW-1:0]  q_mem_q [pLQ];
  logic [QW-1:0]  q_head_q, q_tail_q;
  logic [CW-1:0]  q_cnt_q;

  logic           wr_en, discard, drop, push, pop, sop_go, rd_fire, q_full, buf_full;
  logic [pAW-1:0] wr_addr;

  function automatic logic [pAW-1:0] ptr_inc(input logic [pAW-1:0] p);
    return (p == LastAddr) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] i);
    return (i == QW'(pLQ - 1)) ? '0 : i + 1'b1;
  endfunction

  assign q_full   = (q_cnt_q == CW'(pLQ));
  assign buf_full = (used_q == DepthL);
  assign rd_fire  = (rd_st_q == R_SEND) && iready;

  // Write side. Outside W_RECV, wr_ptr equals cm_ptr, so a new packet always starts at cm_ptr.
  always_comb begin
    wst_d    = wst_q;
    wr_ptr_d = wr_ptr_q;
    cm_ptr_d = cm_ptr_q;
    len_d    = len_q;
    wr_en    = 1'b0;
    wr_addr  = wr_ptr_q;
    discard  = 1'b0;
    drop     = 1'b0;
    push     = 1'b0;
    sop_go   = 1'b0;
    if (ivalid) begin
      case (wst_q)
        W_RECV: begin
          if (isop) begin
            discard = 1'b1;
            drop    = 1'b1;
            sop_go  = 1'b1;
          end else if (buf_full) begin
            discard  = 1'b1;
            drop     = 1'b1;
            wr_ptr_d = cm_ptr_q;
            wst_d    = ieop ? W_IDLE : W_DROP;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = ptr_inc(wr_ptr_q);
            len_d    = len_q + 1'b1;
            if (ieop) begin
              push     = 1'b1;
              cm_ptr_d = ptr_inc(wr_ptr_q);
              wst_d    = W_IDLE;
            end
          end
        end
        default: begin
          if (isop) begin
            sop_go = 1'b1;
          end else if (wst_q == W_DROP && ieop) begin
            wst_d = W_IDLE;
          end
        end
      endcase
      if (sop_go) begin
        // A discarded packet always held at least one byte, so space is guaranteed then.
        if (!q_full && (discard || !buf_full)) begin
          wr_en    = 1'b1;
          wr_addr  = cm_ptr_q;
          wr_ptr_d = ptr_inc(cm_ptr_q);
          len_d    = LW'(1);
          if (ieop) begin
            push     = 1'b1;
            cm_ptr_d = ptr_inc(cm_ptr_q);
            wst_d    = W_IDLE;
          end else begin
            wst_d = W_RECV;
          end
        end else begin
          drop     = 1'b1;
          wr_ptr_d = cm_ptr_q;
          wst_d    = ieop ? W_IDLE : W_DROP;
        end
      end
    end
  end

  always_comb begin
    used_d = used_q - (discard ? len_q : '0) + LW'(wr_en) - LW'(rd_fire);
  end

  // Read side.
  always_comb begin
    rd_st_d  = rd_st_q;
    rd_ptr_d = rd_ptr_q;
    rem_d    = rem_q;
    first_d  = first_q;
    pop      = 1'b0;
    case (rd_st_q)
      R_IDLE: begin
        if (q_cnt_q != '0) begin
          rem_d   = q_mem_q[q_head_q];
          first_d = 1'b1;
          rd_st_d = R_SEND;
        end
      end
      default: begin
        if (iready) begin
          rd_ptr_d = ptr_inc(rd_ptr_q);
          rem_d    = rem_q - 1'b1;
          first_d  = 1'b0;
          if (rem_q == LW'(1)) begin
            pop     = 1'b1;
            rd_st_d = R_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      wst_q    <= W_IDLE;
      rd_st_q  <= R_IDLE;
      wr_ptr_q <= '0;
      cm_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
      used_q   <= '0;
      rem_q    <= '0;
      first_q  <= 1'b0;
      q_head_q <= '0;
      q_tail_q <= '0;
      q_cnt_q  <= '0;
      for (int i = 0; i < pLQ; i++) begin
        q_mem_q[i] <= '0;
      end
    end else begin
      wst_q    <= wst_d;
      rd_st_q  <= rd_st_d;
      wr_ptr_q <= wr_ptr_d;
      cm_ptr_q <= cm_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
      used_q   <= used_d;
      rem_q    <= rem_d;
      first_q  <= first_d;
      q_cnt_q  <= q_cnt_q + CW'(push) - CW'(pop);
      if (push) begin
        q_mem_q[q_tail_q] <= len_d;
        q_tail_q          <= q_inc(q_tail_q);
      end
      if (pop) begin
        q_head_q <= q_inc(q_head_q);
      end
    end
  end

  // Write strobe and drop pulse track the input byte combinationally; reset forces them low.
  assign omem_wr_en  = irst_n & wr_en;
  assign omem_w_addr = wr_addr;
  assign omem_w_data = omem_wr_en ? idata : '0;
  assign odrop       = irst_n & drop;
  assign omem_r_addr = rd_ptr_q;
  assign ovalid      = (rd_st_q == R_SEND);
  assign osop        = ovalid & first_q;
  assign oeop        = ovalid & (rem_q == LW'(1));
  assign odata       = ovalid ? imem_r_data : '0;
  assign opkt_cnt    = q_cnt_q;

endmodule

// File: tb/tb_pkt_ring_ctrl.sv
// Bench for pkt_ring_ctrl: byte-queue reference model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic with output stalls.
module tb_pkt_ring_ctrl;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int LQ    = 4;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       ivalid = 1'b0, isop = 1'b0, ieop = 1'b0, iready = 1'b1;
  logic [7:0] idata = '0;
  logic       mem_wr_en, ovalid, osop, oeop, odrop;
  logic [AW-1:0] mem_w_addr, mem_r_addr;
  logic [7:0] mem_w_data, mem_r_data, odata;
  logic [2:0] opkt_cnt;
  logic [7:0] mem [DEPTH];

  pkt_ring_ctrl #(.pBITS(8), .pDEPTH(DEPTH), .pAW(AW), .pLQ(LQ)) dut (
    .iclk(clk), .irst_n(rst_n), .ivalid(ivalid), .isop(isop), .ieop(ieop), .idata(idata),
    .omem_wr_en(mem_wr_en), .omem_w_addr(mem_w_addr), .omem_w_data(mem_w_data),
    .omem_r_addr(mem_r_addr), .imem_r_data(mem_r_data),
    .ovalid(ovalid), .osop(osop), .oeop(oeop), .odata(odata), .iready(iready),
    .odrop(odrop), .opkt_cnt(opkt_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_wr_en) mem[mem_w_addr] <= mem_w_data;
  assign mem_r_data = mem[mem_r_addr];

  int n_cmp = 0, n_fail = 0, cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Model: committed bytes still to be sent, their packet lengths, and the packet being received.
  logic [7:0] pk_bytes[$], ip_bytes[$];
  int pk_len[$];
  int m_mode = 0, m_base = 0, m_idx = 0;
  bit m_send = 0;
  int wlog[$], ocyc[$], dcyc[$];
  logic [9:0] olog[$];

  task automatic model_commit();
    pk_len.push_back(ip_bytes.size());
    foreach (ip_bytes[i]) pk_bytes.push_back(ip_bytes[i]);
    m_base = (m_base + ip_bytes.size()) % DEPTH;
    ip_bytes.delete();
    m_mode = 0;
  endtask

  always @(negedge clk) begin : model
    int used, n0, disc, waddr;
    bit wen, drp, sop_go;
    if (!rst_n) begin
      check("rst_wr_en", mem_wr_en, 0);
      check("rst_w_addr", mem_w_addr, 0);
      check("rst_w_data", mem_w_data, 0);
      check("rst_r_addr", mem_r_addr, 0);
      check("rst_ovalid", ovalid, 0);
      check("rst_osop", osop, 0);
      check("rst_oeop", oeop, 0);
      check("rst_odata", odata, 0);
      check("rst_odrop", odrop, 0);
      check("rst_pkt_cnt", opkt_cnt, 0);
      pk_bytes.delete(); ip_bytes.delete(); pk_len.delete();
      m_mode = 0; m_base = 0; m_idx = 0; m_send = 0;
    end else begin
      used = pk_bytes.size() + ip_bytes.size();
      n0   = pk_len.size();
      check("ovalid", ovalid, m_send);
      if (m_send) begin
        check("osop", osop, m_idx == 0);
        check("oeop", oeop, m_idx == pk_len[0] - 1);
        check("odata", odata, pk_bytes[0]);
      end
      check("opkt_cnt", opkt_cnt, n0);
      if (mem_wr_en) wlog.push_back(int'(mem_w_addr));
      if (ovalid && iready) begin
        olog.push_back({osop, oeop, odata});
        ocyc.push_back(cyc_n);
      end
      if (odrop) dcyc.push_back(cyc_n);
      // Read side, from start-of-cycle queue contents.
      if (m_send) begin
        if (iready) begin
          void'(pk_bytes.pop_front());
          m_idx++;
          if (m_idx == pk_len[0]) begin
            void'(pk_len.pop_front());
            m_send = 0;
            m_idx = 0;
          end
        end
      end else if (n0 > 0) begin
        m_send = 1;
        m_idx = 0;
      end
      // Write side.
      wen = 0; drp = 0; sop_go = 0; disc = 0; waddr = 0;
      if (ivalid) begin
        if (m_mode == 1 && isop) begin
          disc = ip_bytes.size(); drp = 1; sop_go = 1; ip_bytes.delete();
        end else if (m_mode == 1) begin
          if (used == DEPTH) begin
            drp = 1; ip_bytes.delete(); m_mode = ieop ? 0 : 2;
          end else begin
            wen = 1; waddr = (m_base + ip_bytes.size()) % DEPTH;
            ip_bytes.push_back(idata);
            if (ieop) model_commit();
          end
        end else if (isop) begin
          sop_go = 1;
        end else if (m_mode == 2 && ieop) begin
          m_mode = 0;
        end
        if (sop_go) begin
          if (used - disc < DEPTH && n0 < LQ) begin
            wen = 1; waddr = m_base;
            ip_bytes.push_back(idata);
            if (ieop) model_commit(); else m_mode = 1;
          end else begin
            drp = 1; m_mode = ieop ? 0 : 2;
          end
        end
      end
      check("wr_en", mem_wr_en, wen);
      if (wen) begin
        check("w_addr", mem_w_addr, waddr);
        check("w_data", mem_w_data, idata);
      end
      check("odrop", odrop, drp);
    end
  end

  task automatic step(input bit v, input bit s, input bit e, input logic [7:0] d);
    ivalid = v; isop = s; ieop = e; idata = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00);
  endtask

  task automatic send_pkt(input int n, input logic [7:0] b);
    for (int i = 0; i < n; i++) step(1, i == 0, i == n - 1, b + 8'(i));
  endtask

  int w0, o0, d0, ec, c9, eops, remaining;
  bit done;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Three-byte packet through an idle ring.
    w0 = wlog.size(); o0 = olog.size();
    step(1, 1, 0, 8'h11); step(1, 0, 0, 8'h22);
    ec = cyc_n; step(1, 0, 1, 8'h33);
    idle(6);
    check("p3_wr_count", wlog.size() - w0, 3);
    if (wlog.size() >= w0 + 3) begin
      check("p3_addr0", wlog[w0], 0); check("p3_addr1", wlog[w0+1], 1);
      check("p3_addr2", wlog[w0+2], 2);
    end
    check("p3_out_count", olog.size() - o0, 3);
    if (olog.size() >= o0 + 3) begin
      check("p3_out0", olog[o0], {2'b10, 8'h11});
      check("p3_out1", olog[o0+1], {2'b00, 8'h22});
      check("p3_out2", olog[o0+2], {2'b01, 8'h33});
      check("p3_latency", ocyc[o0], ec + 2);
    end

    // Single-byte packet.
    o0 = olog.size();
    step(1, 1, 1, 8'hA5); idle(4);
    check("p1_out_count", olog.size() - o0, 1);
    if (olog.size() > o0) check("p1_out", olog[o0], {2'b11, 8'hA5});

    // Wrap: 2-byte filler then 4 bytes from address 6.
    send_pkt(2, 8'hB0); idle(4);
    w0 = wlog.size(); o0 = olog.size();
    send_pkt(4, 8'hC0); idle(8);
    check("wrap_wr_count", wlog.size() - w0, 4);
    if (wlog.size() >= w0 + 4) begin
      check("wrap_a0", wlog[w0], 6); check("wrap_a1", wlog[w0+1], 7);
      check("wrap_a2", wlog[w0+2], 0); check("wrap_a3", wlog[w0+3], 1);
    end
    if (olog.size() >= o0 + 4) begin
      check("wrap_d0", olog[o0], {2'b10, 8'hC0}); check("wrap_d3", olog[o0+3], {2'b01, 8'hC3});
    end

    // Oversized packet with output stalled: drop at the 9th byte, next packet at restored pointer.
    iready = 0;
    idle(1);
    w0 = wlog.size(); d0 = dcyc.size();
    for (int i = 0; i < 10; i++) begin
      if (i == 8) c9 = cyc_n;
      step(1, i == 0, i == 9, 8'(i));
    end
    check("ovf_drops", dcyc.size() - d0, 1);
    if (dcyc.size() > d0) check("ovf_drop_cycle", dcyc[d0], c9);
    check("ovf_wr_count", wlog.size() - w0, 8);
    check("ovf_pkt_cnt", opkt_cnt, 0);
    send_pkt(3, 8'hD0); idle(3);
    if (wlog.size() > w0 + 8) check("ovf_restart_addr", wlog[w0+8], 2);
    check("ovf_next_cnt", opkt_cnt, 1);

    // Fill the packet queue; a fifth packet is dropped, then exactly four drain.
    send_pkt(1, 8'hE0); send_pkt(1, 8'hE1); send_pkt(2, 8'hE2); idle(2);
    check("lq_full_cnt", opkt_cnt, 4);
    d0 = dcyc.size(); o0 = olog.size();
    send_pkt(1, 8'hF0); idle(2);
    check("lq_drops", dcyc.size() - d0, 1);
    check("lq_cnt_after", opkt_cnt, 4);
    iready = 1;
    idle(25);
    eops = 0;
    for (int i = o0; i < olog.size(); i++) if (olog[i][8]) eops++;
    check("lq_drained_pkts", eops, 4);
    check("lq_drained_bytes", olog.size() - o0, 7);
    check("lq_empty_cnt", opkt_cnt, 0);

    // Reset in the middle of a packet, then a fresh 2-byte packet.
    w0 = wlog.size(); o0 = olog.size(); d0 = dcyc.size();
    step(1, 1, 0, 8'h01);
    rst_n = 0;
    step(1, 0, 0, 8'h02);
    idle(2);
    rst_n = 1;
    idle(1);
    send_pkt(2, 8'h5A); idle(6);
    check("rst_no_drop", dcyc.size() - d0, 0);
    check("rst_wr_count", wlog.size() - w0, 3);
    if (wlog.size() >= w0 + 3) begin
      check("rst_new_a0", wlog[w0+1], 0); check("rst_new_a1", wlog[w0+2], 1);
    end
    check("rst_out_count", olog.size() - o0, 2);
    if (olog.size() >= o0 + 2) begin
      check("rst_out0", olog[o0], {2'b10, 8'h5A}); check("rst_out1", olog[o0+1], {2'b01, 8'h5B});
    end

    // Randomized traffic with stall phases.
    remaining = 0;
    for (int c = 0; c < 3000; c++) begin
      bit v, s, e;
      if ((c / 150) % 3 == 2) iready = 0;
      else iready = ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 3) != 0); s = 0; e = 0;
      if (v) begin
        if (remaining == 0 && $urandom_range(0, 9) == 0) begin
          e = 1'($urandom_range(0, 1));
        end else begin
          if (remaining == 0 || $urandom_range(0, 29) == 0) begin
            s = 1; remaining = $urandom_range(1, 10);
          end
          e = (remaining == 1);
          remaining--;
        end
      end
      step(v, s, e, 8'($urandom));
    end

    // Drain everything committed, bounded.
    iready = 1;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      step(0, 0, 0, 8'h00);
      if (pk_len.size() == 0 && !m_send) done = 1;
    end
    check("drain_done", done, 1);
    idle(2);
    check("final_pkt_cnt", opkt_cnt, 0);
    check("final_ovalid", ovalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
